// File: rtl/tone_pkg.sv
// ============================================================================
// tone_pkg : shared constants for the buzzer tone player and tone_decoder
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package tone_pkg;

  localparam int          NUM_NOTES    = 14;
  localparam logic [18:0] TIMEOUT      = 19'd262143;
  localparam logic [3:0]  NOTE_SILENCE = 4'd15;
  localparam int          TOL_SHIFT    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    CHECK = 2'd2,
    LOCK  = 2'd3
  } state_e;

  // Half-period table in clk cycles, L_1..L_7 then M_1..M_7; the player reads this too.
  localparam logic [18:0] HALF_PERIOD [NUM_NOTES] = '{
    19'd127552, 19'd113636, 19'd101236, 19'd95548, 19'd85136, 19'd75838, 19'd67567,
    19'd63776,  19'd56818,  19'd50607,  19'd47778, 19'd42553, 19'd37936, 19'd33783
  };

  function automatic logic [18:0] nom_period(input logic [3:0] k);
    return (HALF_PERIOD[k] + 19'd1) << 1;
  endfunction

  function automatic logic in_tolerance(input logic [18:0] meas, input logic [18:0] nom);
    logic [18:0] diff;
    diff = (meas >= nom) ? (meas - nom) : (nom - meas);
    return (diff <= (nom >> TOL_SHIFT));
  endfunction

endpackage

`default_nettype wire

// File: rtl/tone_edge_sync.sv
// ============================================================================
// tone_edge_sync : 2-flop synchronizer, optional deglitch filter
//                  (TONE_DECODER_DEGLITCH_EN) and registered rising-edge strobe
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module tone_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic edge_stb
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic edge_q, edge_d;
  logic level;

`ifdef TONE_DECODER_DEGLITCH_EN
  logic       filt_q, filt_d;
  logic [1:0] run_q, run_d;

  // The filtered level flips only on the 4th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    run_d  = 2'd0;
    if (sync2_q != filt_q) begin
      if (run_q == 2'd3) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      run_q  <= 2'd0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d = tone_in;
    sync2_d = sync1_q;
    prev_d  = level;
    edge_d  = level & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
    end
  end

  assign edge_stb = edge_q;

endmodule

`default_nettype wire

// File: rtl/tone_decoder.sv
// ============================================================================
// tone_decoder : measures the buzzer square-wave period and decodes the note
//                (input deglitch selected by TONE_DECODER_DEGLITCH_EN)
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tone_decoder
  import tone_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [3:0]  note,
  output logic        note_valid,
  output logic        locked,
  output logic [18:0] period
);

  logic        edge_stb;
  logic        timeout;
  logic        hit;
  logic [3:0]  hit_idx;

  state_e      state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic [18:0] period_q, period_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  note_q, note_d;
  logic        locked_q, locked_d;
  logic        note_valid_q, note_valid_d;

  tone_edge_sync u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .tone_in  (tone_in),
    .edge_stb (edge_stb)
  );

  // On a strobe cycle cnt_q already spans the whole period, strobe cycle included.
  always_comb begin
    hit     = 1'b0;
    hit_idx = NOTE_SILENCE;
    for (int k = 0; k < NUM_NOTES; k++) begin
      if (in_tolerance(cnt_q, nom_period(4'(k)))) begin
        hit     = 1'b1;
        hit_idx = 4'(k);
      end
    end
  end

  assign timeout = (cnt_q == TIMEOUT) && !edge_stb;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    cand_d   = cand_q;
    note_d   = note_q;
    locked_d = locked_q;

    if (edge_stb) begin
      cnt_d    = 19'd1;
      period_d = cnt_q;
    end else if (cnt_q != TIMEOUT) begin
      cnt_d = cnt_q + 19'd1;
    end

    if (edge_stb) begin
      case (state_q)
        IDLE: state_d = ACQ;
        ACQ: begin
          if (hit) begin
            cand_d  = hit_idx;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (hit && (hit_idx == cand_q)) begin
            state_d  = LOCK;
            note_d   = cand_q;
            locked_d = 1'b1;
          end else if (hit) begin
            cand_d = hit_idx;
          end else begin
            state_d = ACQ;
          end
        end
        LOCK: begin
          if (!(hit && (hit_idx == note_q))) begin
            state_d  = ACQ;
            note_d   = NOTE_SILENCE;
            locked_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d  = IDLE;
      note_d   = NOTE_SILENCE;
      locked_d = 1'b0;
    end

    note_valid_d = (note_d != note_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 19'd0;
      period_q     <= 19'd0;
      cand_q       <= 4'd0;
      note_q       <= NOTE_SILENCE;
      locked_q     <= 1'b0;
      note_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      cand_q       <= cand_d;
      note_q       <= note_d;
      locked_q     <= locked_d;
      note_valid_q <= note_valid_d;
    end
  end

  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign locked     = locked_q;
  assign period     = period_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_decoder.sv
// ============================================================================
// tb_tone_decoder : directed self-checking bench for tone_decoder
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module tb_tone_decoder;
  import tone_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tone_in = 1'b0;
  logic [3:0]  note;
  logic        note_valid;
  logic        locked;
  logic [18:0] period;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;
  int rise_cyc = 0;
  int p0 = 0;

`ifdef TONE_DECODER_DEGLITCH_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 4;
`endif

  always #5 clk = ~clk;

  tone_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .note       (note),
    .note_valid (note_valid),
    .locked     (locked),
    .period     (period)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (note_valid) begin
      pulses    <= pulses + 1;
      pulse_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      tone_in  = 1'b1;
      rise_cyc = cyc;
      tick(hi);
      tone_in  = 1'b0;
      tick(lo);
    end
  endtask

  initial begin
    tick(3);
    chk("rst_note", int'(note), 15);
    chk("rst_locked", int'(locked), 0);
    chk("rst_valid", int'(note_valid), 0);
    chk("rst_period", int'(period), 0);
    rst = 1'b0;
    tick(2);

    // M_1 at half-period 63777: lock on the 3rd rising edge
    wave(63777, 63777, 2);
    chk("m1_pre_locked", int'(locked), 0);
    chk("m1_pre_note", int'(note), 15);
    wave(63777, 63777, 1);
    chk("m1_note", int'(note), 7);
    chk("m1_locked", int'(locked), 1);
    chk("m1_period", int'(period), 127554);
    chk("m1_pulses", pulses, 1);
    chk("m1_latency", pulse_cyc - rise_cyc, LAT);

    // Stop toggling: timeout returns to silence
    p0 = pulses;
    for (int i = 0; i < 300000 && pulses == p0; i++) tick(1);
    chk("to_pulse", pulses - p0, 1);
    chk("to_note", int'(note), 15);
    chk("to_locked", int'(locked), 0);
    chk("to_delay", pulse_cyc - rise_cyc, int'(TIMEOUT) + LAT);
    tick(10);
    chk("to_single", pulses - p0, 1);
    chk("to_period", int'(period), 127554);

    // L_3 then switch to L_4 after a high phase
    p0 = pulses;
    wave(101237, 101237, 3);
    chk("l3_note", int'(note), 2);
    chk("l3_locked", int'(locked), 1);
    chk("l3_pulses", pulses - p0, 1);
    tone_in  = 1'b1;
    rise_cyc = cyc;
    tick(101237);
    tone_in  = 1'b0;
    tick(95549);
    wave(95549, 95549, 1);
    chk("sw_note", int'(note), 15);
    chk("sw_locked", int'(locked), 0);
    chk("sw_pulses", pulses - p0, 2);
    wave(95549, 95549, 1);
    chk("l4_check_note", int'(note), 15);
    wave(95549, 95549, 1);
    chk("l4_note", int'(note), 3);
    chk("l4_locked", int'(locked), 1);
    chk("l4_period", int'(period), 191098);
    chk("l4_pulses", pulses - p0, 3);

    // Reset pulsed while locked
    p0  = pulses;
    rst = 1'b1;
    tick(1);
    chk("mr_locked", int'(locked), 0);
    chk("mr_note", int'(note), 15);
    chk("mr_period", int'(period), 0);
    chk("mr_valid", int'(note_valid), 0);
    rst = 1'b0;
    tick(3);
    chk("mr_no_pulse", pulses - p0, 0);

    // M_7 tolerance boundary: 68624 out, 68623 in
    wave(34312, 34312, 4);
    chk("tol_out_locked", int'(locked), 0);
    chk("tol_out_note", int'(note), 15);
    chk("tol_out_period", int'(period), 68624);
    chk("tol_out_pulses", pulses - p0, 0);
    wave(34311, 34312, 3);
    chk("tol_in_note", int'(note), 13);
    chk("tol_in_locked", int'(locked), 1);
    chk("tol_in_period", int'(period), 68623);

`ifdef TONE_DECODER_DEGLITCH_EN
    // 2-clk glitch inside a high phase must be invisible
    p0       = pulses;
    tone_in  = 1'b1;
    rise_cyc = cyc;
    tick(10000);
    tone_in  = 1'b0;
    tick(2);
    tone_in  = 1'b1;
    tick(24309);
    tone_in  = 1'b0;
    tick(34312);
    wave(34311, 34312, 1);
    chk("dg_locked", int'(locked), 1);
    chk("dg_period", int'(period), 68623);
    chk("dg_pulses", pulses - p0, 0);
`endif

    // Off-table half-period 90000 never locks
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    p0 = pulses;
    wave(90000, 90000, 4);
    chk("off_locked", int'(locked), 0);
    chk("off_note", int'(note), 15);
    chk("off_period", int'(period), 180000);
    chk("off_pulses", pulses - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
